// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// IF-stage branch predictor. A single direct-mapped table holds, per entry,
// a valid bit, a tag, a branch target and a saturating direction counter.
// The table is indexed by pc[INDEX_BITS:1]. In gshare mode (MODE=1) the
// global history is XORed into the low index bits. Speculative global
// history advances on predicted hits. When WB reports a mispredict, the
// history is rebuilt from the snapshot that travelled with the branch.
// Two saturating counters track resolved branches and mispredicts.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-low reset
//   lookup_en        fetch advances this cycle (IF not stalled)
//   pc_if            fetch PC (lookup is combinational)
//   predict_taken    predicted taken for pc_if
//   target_pc        predicted target (0 when not predicted taken)
//   hist_if          history used for this lookup, carried down the pipe
//   update_en        resolved branch in WB (single-cycle pulse)
//   pc_wb            resolved branch PC
//   hist_wb          history snapshot carried with the resolved branch
//   actual_taken     resolved direction
//   actual_target    resolved target
//   mispredict       WB flush for this branch, qualified by update_en
//   stat_branches    saturating resolved-branch count
//   stat_mispredicts saturating mispredict count
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned HIST_BITS  = 2,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned TAG_BITS   = 8,
    parameter bit          MODE       = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lookup_en,
    input  logic [15:0]          pc_if,
    output logic                 predict_taken,
    output logic [15:0]          target_pc,
    output logic [HIST_BITS-1:0] hist_if,
    input  logic                 update_en,
    input  logic [15:0]          pc_wb,
    input  logic [HIST_BITS-1:0] hist_wb,
    input  logic                 actual_taken,
    input  logic [15:0]          actual_target,
    input  logic                 mispredict,
    output logic [15:0]          stat_branches,
    output logic [15:0]          stat_mispredicts
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
    logic [15:0]           target_q [ENTRIES];
    logic [15:0]           target_d [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_d    [ENTRIES];

    logic [HIST_BITS-1:0]  ghr_q;
    logic [HIST_BITS-1:0]  ghr_d;
    logic [15:0]           stat_branches_q;
    logic [15:0]           stat_branches_d;
    logic [15:0]           stat_mispredicts_q;
    logic [15:0]           stat_mispredicts_d;

    // ------------------------------------------------------------------
    // Index / tag helpers
    // ------------------------------------------------------------------
    function automatic logic [INDEX_BITS-1:0] calc_idx(
        input logic [15:0]          pc,
        input logic [HIST_BITS-1:0] hist
    );
        logic [INDEX_BITS-1:0] base;
        logic [INDEX_BITS-1:0] hist_ext;
        base     = pc[INDEX_BITS:1];
        hist_ext = INDEX_BITS'(hist);
        return MODE ? (base ^ hist_ext) : base;
    endfunction

    function automatic logic [TAG_BITS-1:0] calc_tag(input logic [15:0] pc);
        return pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    endfunction

    // Not every PC bit feeds the index or tag; fold them here so the
    // unused bits are accounted for explicitly.
    logic unused_in_bits;
    assign unused_in_bits = ^{pc_if, pc_wb, hist_wb};

    // ------------------------------------------------------------------
    // Lookup (combinational, reads pre-update table contents)
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic                  lk_hit;

    always_comb begin
        lk_idx        = calc_idx(pc_if, ghr_q);
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == calc_tag(pc_if));
        predict_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
        target_pc     = predict_taken ? target_q[lk_idx] : '0;
        hist_if       = ghr_q;
    end

    // ------------------------------------------------------------------
    // History next values. The single-bit case has no older bits to keep,
    // so it is split out to avoid a negative-width slice.
    // ------------------------------------------------------------------
    logic [HIST_BITS-1:0] spec_hist;
    logic [HIST_BITS-1:0] repair_hist;

    if (HIST_BITS == 1) begin : g_hist1
        assign spec_hist   = predict_taken;
        assign repair_hist = actual_taken;
    end else begin : g_histn
        assign spec_hist   = {ghr_q[HIST_BITS-2:0], predict_taken};
        assign repair_hist = {hist_wb[HIST_BITS-2:0], actual_taken};
    end

    always_comb begin
        ghr_d = ghr_q;
        if (lookup_en && lk_hit) begin
            ghr_d = spec_hist;
        end
        // Repair from WB overrides any speculative shift in the same cycle.
        if (update_en && mispredict) begin
            ghr_d = repair_hist;
        end
    end

    // ------------------------------------------------------------------
    // Table update from WB
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] up_idx;
    logic                  up_hit;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        up_idx = calc_idx(pc_wb, hist_wb);
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == calc_tag(pc_wb));

        if (update_en) begin
            if (up_hit) begin
                if (actual_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
                    end
                    target_d[up_idx] = actual_target;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
                end
            end else if (actual_taken) begin
                // Allocate over whatever occupied the slot.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = calc_tag(pc_wb);
                target_d[up_idx] = actual_target;
                ctr_d[up_idx]    = CTR_WT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics (saturating)
    // ------------------------------------------------------------------
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (update_en) begin
            if (stat_branches_q != 16'hFFFF) begin
                stat_branches_d = stat_branches_q + 16'd1;
            end
            if (mispredict && (stat_mispredicts_q != 16'hFFFF)) begin
                stat_mispredicts_d = stat_mispredicts_q + 16'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q            <= '{default: 1'b0};
            tag_q              <= '{default: '0};
            target_q           <= '{default: '0};
            ctr_q              <= '{default: CTR_WNT};
            ghr_q              <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            ghr_q              <= ghr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the fixed 2-bit-history predictor and BTB used in the IF stage of the LC-3b pipeline.
- Combines tagged BTB targets and saturating direction counters in one table, indexed by bimodal or gshare.
- Keeps speculative global history, with repair from the WB-stage snapshot on mispredict.
- Provides saturating statistics counters.
- Lookup is combinational in IF; update arrives from WB.

Parameters:
INDEX_BITS, 5, table has 2^INDEX_BITS entries, indexed by pc[INDEX_BITS:1]
HIST_BITS, 2, global history width (>=1, <=INDEX_BITS)
CTR_BITS, 2, saturating counter width (>=1)
TAG_BITS, 8, tag width taken from pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1] (sum <=15)
MODE, 1, 0 = bimodal (history not XORed), 1 = gshare (history XORed into low index bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
lookup_en  in  1  fetch advancing this cycle (IF not stalled)
pc_if  in  16  fetch PC
predict_taken  out  1  predicted taken for pc_if
target_pc  out  16  predicted target
hist_if  out  HIST_BITS  history used for this lookup; carried down the pipe
update_en  in  1  resolved branch in WB, single-cycle pulse
pc_wb  in  16  resolved branch PC
hist_wb  in  HIST_BITS  history snapshot carried with that branch
actual_taken  in  1  resolved direction
actual_target  in  16  resolved target
mispredict  in  1  WB flush for this branch; qualified by update_en
stat_branches  out  16  resolved-branch count
stat_mispredicts  out  16  mispredict count

Behaviour:
- Reset (async, reset=0):
  - all valid bits 0; counters set to 2^(CTR_BITS-1)-1 (weakly not-taken).
  - GHR 0; both stat counters 0.
  - predict_taken=0, target_pc=0, hist_if=0.
- Table storage is flops, so the whole table resets asynchronously.
- Index: idx = pc[INDEX_BITS:1], XORed with GHR zero-extended when MODE=1. Lookup uses pc_if and the GHR. Update uses pc_wb and hist_wb.
- Lookup, combinational in the same cycle:
  - hit = valid[idx] & tag[idx]==tag(pc_if).
  - predict_taken = hit & ctr[idx] MSB.
  - target_pc = target[idx] when predict_taken, else 0.
  - hist_if = GHR.
- Speculative history:
  - At a clock edge with lookup_en & hit & no repair: GHR <= {GHR[HIST_BITS-2:0], predict_taken}.
  - For HIST_BITS=1: GHR <= predict_taken.
  - Lookup misses do not shift the GHR.
- Repair:
  - update_en & mispredict: GHR <= {hist_wb[HIST_BITS-2:0], actual_taken}.
  - Repair has priority over a same-cycle speculative shift.
- Update on a clock edge with update_en:
  - Hit at the update index: counter +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - Hit and taken: target <= actual_target.
  - Miss and taken: allocate (valid=1, tag, target, ctr=2^(CTR_BITS-1), weakly taken), replacing any prior entry.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The write is visible the following cycle.
- Statistics:
  - stat_branches +1 per update_en.
  - stat_mispredicts +1 per update_en & mispredict.
  - Both saturate at 16'hFFFF and do not wrap.
- mispredict without update_en is ignored.
- Reset asserted mid-operation clears everything immediately. The first edge after release behaves as the first cycle after reset.

Test Plan:
1. Defaults; reset released; pc_if=16'h0040, lookup_en=1 -> predict_taken=0, target_pc=0, hist_if=0, stat_branches=0, stat_mispredicts=0; GHR remains 0 (miss).
2. MODE=0; update_en, pc_wb=16'h0010, actual_taken=1, actual_target=16'h0100, mispredict=1 -> next cycle pc_if=16'h0010 gives predict_taken=1, target_pc=16'h0100; same-cycle lookup of 16'h0010 during the update still gives 0.
3. MODE=0, entry from scenario 2 (ctr=2):
   - three not-taken updates -> ctr 1,0,0; predict_taken=0 after the first.
   - two taken updates -> ctr 1 (predict 0), then 2 (predict 1, target unchanged unless actual_target differs).
4. MODE=0, tag alias: pc_if=16'h0050 (same index 8, different tag) -> predict_taken=0; a not-taken update of 16'h0050 leaves the 16'h0010 entry hitting.
5. MODE=1, history:
   - two consecutive taken-predicted hits with lookup_en -> hist_if goes 00, 01, 11.
   - update_en, mispredict=1, hist_wb=2'b00, actual_taken=0, together with a hit lookup_en -> GHR=2'b00 next cycle (repair wins).
6. Statistics: three update_en pulses, one with mispredict -> stat_branches=3, stat_mispredicts=1; preload near saturation -> stays 16'hFFFF; assert reset mid-run -> both 0 immediately.
